// File: rtl/inst_sram.sv
// inst_sram: fixed-latency instruction SRAM with valid/ready fetch port and preload port
// Build option: define INST_SRAM_RAND_DELAY_EN to add 0..7 LFSR-driven extra BUSY cycles per request.
// Ports: clk, rst (async active-low); req_valid/req_ready/req_addr fetch request;
//        resp_valid/resp_ready/resp_data/resp_err fetch response; load_en/load_addr/load_data preload write.
module inst_sram #(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int          DEPTH_LOG2 = 12,
   parameter int          LATENCY    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_data,
   output logic                  resp_err,
   input  logic                  load_en,
   input  logic [DEPTH_LOG2-1:0] load_addr,
   input  logic [31:0]           load_data
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t      state, state_nx;
   logic [4:0]  cnt;
   logic [4:0]  extra;
   logic [31:0] addr_q;
   logic [31:0] word;
   logic        err;
   logic [31:0] mem [2**DEPTH_LOG2];
`ifdef INST_SRAM_RAND_DELAY_EN
   logic [7:0]  lfsr;
   always_ff @(posedge clk or negedge rst)
      if (!rst) lfsr <= 8'hA5;
      else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign extra = {2'b0, lfsr[2:0]};
`else
   assign extra = 5'd0;
`endif
   // Unsigned subtraction wraps addresses below BASE_ADDR to huge indices, so one range test covers both sides.
   assign word = (addr_q - BASE_ADDR) >> 2;
   assign err  = (addr_q[1:0] != 2'b00) || ((word >> DEPTH_LOG2) != 32'd0);
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   always_comb begin
      state_nx = state;
      if (state == IDLE && req_valid)       state_nx = BUSY;
      else if (state == BUSY && cnt == 5'd0) state_nx = RESP;
      else if (state == RESP && resp_ready)  state_nx = IDLE;
   end
   always_comb begin
      req_ready  = state == IDLE;
      resp_valid = state == RESP;
   end
   // Reading mem here with a non-blocking write in the other block yields pre-write data on a same-edge collision.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cnt       <= 5'd0;
         addr_q    <= 32'd0;
         resp_data <= 32'd0;
         resp_err  <= 1'b0;
      end else if (state == IDLE && req_valid) begin
         addr_q <= req_addr;
         cnt    <= 5'(LATENCY - 1) + extra;
      end else if (state == BUSY) begin
         if (cnt != 5'd0) cnt <= cnt - 5'd1;
         else begin
            resp_data <= err ? 32'd0 : mem[word[DEPTH_LOG2-1:0]];
            resp_err  <= err;
         end
      end
   always_ff @(posedge clk)
      if (load_en) mem[load_addr] <= load_data;
endmodule
